// File: rtl/micro_sequencer.sv
// Microprogram sequencer: steps a micro-PC through an asynchronous microcode ROM,
// with a return stack, RDY stall, NMI/IRQ entry at FETCH boundaries, halt and stack-error reporting.
module micro_sequencer #(
  parameter int                 UADDR_W     = 8,
  parameter int                 CTL_W       = 64,
  parameter int                 NCOND       = 8,
  parameter int                 STACK_DEPTH = 2,
  parameter logic [UADDR_W-1:0] RESET_ADDR  = 0,
  parameter logic [UADDR_W-1:0] FETCH_ADDR  = 1,
  parameter logic [UADDR_W-1:0] IRQ_ADDR    = 2,
  parameter logic [UADDR_W-1:0] NMI_ADDR    = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  output logic [UADDR_W-1:0]       uaddr,
  input  logic [2:0]               u_op,
  input  logic [UADDR_W-1:0]       u_target,
  input  logic [$clog2(NCOND)-1:0] u_cond,
  input  logic                     u_pol,
  input  logic [CTL_W-1:0]         u_ctl,
  input  logic [UADDR_W-1:0]       map_addr,
  input  logic [NCOND-1:0]         cond_vec,
  input  logic                     i_flag,
  input  logic                     irq,
  input  logic                     nmi,
  output logic [CTL_W-1:0]         ctl_out,
  output logic                     ir_ld,
  output logic                     int_ack,
  output logic [1:0]               int_sel,
  output logic                     halted,
  output logic                     stk_err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int STK_N = 1 << SP_W;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_BRANCH   = 3'd2;
  localparam logic [2:0] OP_DISPATCH = 3'd3;
  localparam logic [2:0] OP_CALL     = 3'd4;
  localparam logic [2:0] OP_RET      = 3'd5;
  localparam logic [2:0] OP_FETCH    = 3'd6;

  logic [UADDR_W-1:0] upc_q, upc_d, upc_inc, stk_top;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [UADDR_W-1:0] stack_q [STK_N];
  logic               nmi_prev_q;
  logic               nmi_pend_q, nmi_pend_d;
  logic               halted_q, halted_d;
  logic               stk_err_q, stk_err_d;
  logic               active, is_fetch, take_nmi, take_irq, push_en;

  // rdy acts as a plain enable: rdy=1 commits this cycle's decode, rdy=0 freezes
  // upc/stack/halt and blanks every datapath-facing output for that cycle.
  assign active   = rdy & ~halted_q;
  assign is_fetch = active & (u_op == OP_FETCH);
  assign take_nmi = is_fetch & nmi_pend_q;
  assign take_irq = is_fetch & ~nmi_pend_q & irq & ~i_flag;
  assign upc_inc  = upc_q + UADDR_W'(1);
  assign stk_top  = stack_q[sp_q - SP_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q      <= RESET_ADDR;
      sp_q       <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      halted_q   <= 1'b0;
      stk_err_q  <= 1'b0;
    end else begin
      upc_q      <= upc_d;
      sp_q       <= sp_d;
      nmi_prev_q <= nmi;
      nmi_pend_q <= nmi_pend_d;
      halted_q   <= halted_d;
      stk_err_q  <= stk_err_d;
    end
  end

  // Stack storage needs no reset: an empty depth counter makes old entries unreachable.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q] <= upc_inc;
  end

  always_comb begin
    upc_d      = upc_q;
    sp_d       = sp_q;
    halted_d   = halted_q;
    stk_err_d  = stk_err_q;
    push_en    = 1'b0;
    nmi_pend_d = (nmi & ~nmi_prev_q) | (nmi_pend_q & ~take_nmi);
    if (active) begin
      case (u_op)
        OP_NEXT:     upc_d = upc_inc;
        OP_JUMP:     upc_d = u_target;
        OP_BRANCH:   upc_d = (cond_vec[u_cond] == u_pol) ? u_target : upc_inc;
        OP_DISPATCH: upc_d = map_addr;
        OP_CALL: begin
          upc_d = u_target;
          if (sp_q == SP_W'(STACK_DEPTH)) begin
            stk_err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            upc_d     = FETCH_ADDR;
            stk_err_d = 1'b1;
          end else begin
            upc_d = stk_top;
            sp_d  = sp_q - SP_W'(1);
          end
        end
        OP_FETCH: begin
          if (take_nmi)      upc_d = NMI_ADDR;
          else if (take_irq) upc_d = IRQ_ADDR;
          else               upc_d = FETCH_ADDR + UADDR_W'(1);
        end
        default:     halted_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    uaddr   = upc_q;
    halted  = halted_q;
    stk_err = stk_err_q;
    ctl_out = '0;
    ir_ld   = 1'b0;
    int_ack = 1'b0;
    int_sel = 2'b00;
    if (rst_n && active) begin
      ctl_out = u_ctl;
      ir_ld   = is_fetch & ~take_nmi & ~take_irq;
      int_ack = take_nmi | take_irq;
      if (take_nmi)      int_sel = 2'b10;
      else if (take_irq) int_sel = 2'b01;
    end
  end

endmodule
